proc_datapath: RTL and testbench
================================

// Module: proc_datapath
// PURPOSE
//   Register-transfer datapath driven by control_unit: eight GPRs R0..R7, accumulator A,
//   result register G, add/sub unit, shared bus mux and the 9-bit instruction register (IR).
//   IR feeds control_unit.iin. control_unit drives the one-hot bus-select and load strobes back in.
//   All state changes on the rising clock edge; the bus and ALU result are combinational.
// PARAMETERS
//   WIDTH     16   data/bus width in bits (min 9; IR takes din[8:0])
//   NUM_REGS  8    general-purpose registers; fixed at 8 (3-bit X/Y fields)
// PORTS
//   clock      in   1          system clock, rising edge
//   resetn     in   1          asynchronous, active-low reset
//   din        in   WIDTH      external data / immediate word
//   ir_in      in   1          load IR <= din[8:0]
//   din_out    in   1          drive din onto bus
//   g_out      in   1          drive G onto bus
//   r_out      in   NUM_REGS   one-hot: drive Rk onto bus
//   r_in       in   NUM_REGS   load Rk <= bus (any subset)
//   a_in       in   1          load A <= bus
//   g_in       in   1          load G <= A +/- bus
//   addsub     in   1          0 = add, 1 = subtract (sampled with g_in)
//   ir         out  9          instruction register -> control_unit.iin
//   bus        out  WIDTH      current bus value (combinational)
//   g_carry    out  1          carry (add) / borrow (sub) of last G load
//   g_zero     out  1          G == 0 after last G load
//   bus_conflict out 1         more than one bus driver asserted this cycle (comb.)
//   regs_flat  out  NUM_REGS*WIDTH  {R7..R0} for debug/verification
// BEHAVIOUR
//   Reset (resetn=0, async, any time): R0..R7, A, G, ir, g_carry = 0; g_zero = 1. Held while low.
//   Bus mux priority: din_out > g_out > r_out[0] > ... > r_out[7]. No driver -> bus = 0.
//   bus_conflict = 1 when more than one of {din_out, g_out, r_out[*]} is high. Mux still resolves
//     by priority. No state is affected by the conflict.
//   Load latency: a strobe high in cycle N -> register holds the bus value of cycle N from edge N+1.
//   r_out[k] & r_in[k] together: Rk reloads its own old value (no change). Several r_in bits
//     load the same bus value.
//   ALU: sum = {1'b0,A} + {1'b0,bus} (add) or {1'b0,A} - {1'b0,bus} (sub), WIDTH+1 bits.
//     G <= sum[WIDTH-1:0], wraps modulo 2^WIDTH. g_carry <= sum[WIDTH] (add: carry-out;
//     sub: borrow, i.e. A < bus unsigned). g_zero <= (sum[WIDTH-1:0] == 0).
//     Flags change only on g_in.
//   a_in & g_in same cycle: G uses the OLD A. A takes the bus value.
//   g_out & g_in same cycle: ALU operand is the old G. G <= A +/- old G.
//   ir_in is independent of the bus: IR <= din[8:0] regardless of the bus drivers.
//   Reset asserted mid-instruction: all state clears immediately. A load strobe on the edge
//     where resetn is low is ignored. First load is on the first edge after resetn rises.
//   No internal FSM sequencing. Timesteps are owned by control_unit. This block is pure storage
//     plus routing.
// STRUCTURE
//   proc_pkg: OP_MV/OP_MVI/OP_ADD/OP_SUB opcode constants, IR field offsets (III=[8:6],
//     XXX=[5:3], YYY=[2:0]), NUM_REGS, default WIDTH. Shared with control_unit.
//   Sub-module proc_regn #(W): W-bit register, async active-low clear, load enable.
//     Instantiated for R0..R7, A, G, and IR (W=9).
//   Bus mux and add/sub are inline in proc_datapath.
// TESTING
//   1. Reset mid-load: r_in=8'h01, din=16'h1234, din_out=1, resetn pulses low mid-cycle
//      -> R0=0, g_zero=1. After release, next edge gives R0=16'h1234.
//   2. mvi/mv: din=16'h00FF, din_out=1, r_in=8'h02. Then r_out=8'h02, r_in=8'h80
//      -> R1=R7=16'h00FF, bus_conflict=0.
//   3. Add wrap: A=16'hFFFF, bus=R2=16'h0001, g_in=1, addsub=0
//      -> G=16'h0000, g_carry=1, g_zero=1.
//   4. Sub borrow: A=16'h0003, bus=16'h0005, addsub=1 -> G=16'hFFFE, g_carry=1, g_zero=0.
//   5. Conflict: din_out=1, r_out=8'h08, din=16'hAAAA, R3=16'h5555
//      -> bus=16'hAAAA, bus_conflict=1.
//   6. Same-cycle a_in&g_in: A=16'h0010, bus=16'h0001, add -> G=16'h0011, A=16'h0001.
//      Also ir_in with din=16'h0177 -> ir=9'h177.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared constants for the simple processor: opcodes, IR field layout, GPR count.
// Imported by the datapath and by control_unit.
package proc_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned NUM_GPRS      = 8;
    localparam int unsigned IR_WIDTH      = 9;

    // IR layout: III (opcode) = [8:6], XXX = [5:3], YYY = [2:0]
    localparam int unsigned III_LSB = 6;
    localparam int unsigned XXX_LSB = 3;
    localparam int unsigned YYY_LSB = 0;
    localparam int unsigned FIELD_W = 3;

    typedef enum logic [2:0] {
        OP_MV  = 3'd0,
        OP_MVI = 3'd1,
        OP_ADD = 3'd2,
        OP_SUB = 3'd3
    } opcode_e;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_op_e;

    function automatic logic [FIELD_W-1:0] ir_iii(input logic [IR_WIDTH-1:0] ir);
        return ir[III_LSB +: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] ir_xxx(input logic [IR_WIDTH-1:0] ir);
        return ir[XXX_LSB +: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] ir_yyy(input logic [IR_WIDTH-1:0] ir);
        return ir[YYY_LSB +: FIELD_W];
    endfunction

endpackage

// File: rtl/proc_regn.sv
// Generic W-bit storage register with asynchronous active-low clear and load enable.
module proc_regn #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/proc_datapath.sv
// Register-transfer datapath: R0..R7, A, G, IR, priority bus mux and add/sub unit.
// All sequencing comes from control_unit through the one-hot bus selects and load strobes.
module proc_datapath
    import proc_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned NUM_REGS = NUM_GPRS
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [WIDTH-1:0]          din,
    input  logic                      ir_in,
    input  logic                      din_out,
    input  logic                      g_out,
    input  logic [NUM_REGS-1:0]       r_out,
    input  logic [NUM_REGS-1:0]       r_in,
    input  logic                      a_in,
    input  logic                      g_in,
    input  logic                      addsub,
    output logic [IR_WIDTH-1:0]       ir,
    output logic [WIDTH-1:0]          bus,
    output logic                      g_carry,
    output logic                      g_zero,
    output logic                      bus_conflict,
    output logic [NUM_REGS*WIDTH-1:0] regs_flat
);

    logic [WIDTH-1:0] r_q [NUM_REGS];
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] g_q;
    logic [WIDTH:0]   sum;

    // General-purpose registers, each loading straight from the bus.
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_gpr
        proc_regn #(
            .W (WIDTH)
        ) u_r (
            .clock  (clock),
            .resetn (resetn),
            .load   (r_in[k]),
            .d      (bus),
            .q      (r_q[k])
        );

        assign regs_flat[k*WIDTH +: WIDTH] = r_q[k];
    end

    proc_regn #(
        .W (WIDTH)
    ) u_a (
        .clock  (clock),
        .resetn (resetn),
        .load   (a_in),
        .d      (bus),
        .q      (a_q)
    );

    proc_regn #(
        .W (WIDTH)
    ) u_g (
        .clock  (clock),
        .resetn (resetn),
        .load   (g_in),
        .d      (sum[WIDTH-1:0]),
        .q      (g_q)
    );

    // IR is fed from din directly, never from the bus.
    proc_regn #(
        .W (IR_WIDTH)
    ) u_ir (
        .clock  (clock),
        .resetn (resetn),
        .load   (ir_in),
        .d      (din[IR_WIDTH-1:0]),
        .q      (ir)
    );

    // Lowest priority is assigned first so higher-priority drivers overwrite it.
    always_comb begin
        bus = '0;
        for (int k = int'(NUM_REGS) - 1; k >= 0; k--) begin
            if (r_out[k]) begin
                bus = r_q[k];
            end
        end
        if (g_out) begin
            bus = g_q;
        end
        if (din_out) begin
            bus = din;
        end
    end

    // A conflict is any driver seen after another driver is already active.
    always_comb begin
        logic seen;
        seen         = din_out;
        bus_conflict = seen & g_out;
        seen         = seen | g_out;
        for (int k = 0; k < int'(NUM_REGS); k++) begin
            bus_conflict = bus_conflict | (seen & r_out[k]);
            seen         = seen | r_out[k];
        end
    end

    always_comb begin
        if (addsub == ALU_SUB) begin
            sum = {1'b0, a_q} - {1'b0, bus};
        end else begin
            sum = {1'b0, a_q} + {1'b0, bus};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            g_carry <= 1'b0;
            g_zero  <= 1'b1;
        end else if (g_in) begin
            g_carry <= sum[WIDTH];
            g_zero  <= (sum[WIDTH-1:0] == '0);
        end
    end

endmodule

// File: tb/tb_proc_datapath.sv
// Directed bench for proc_datapath: expectations are queued as stimulus is driven and
// compared once the corresponding output is due.
module tb_proc_datapath;

    localparam int unsigned W = 16;
    localparam int unsigned N = 8;

    localparam int K_BUS      = 8;
    localparam int K_CARRY    = 9;
    localparam int K_ZERO     = 10;
    localparam int K_CONFLICT = 11;
    localparam int K_IR       = 12;

    logic           clock = 1'b0;
    logic           resetn;
    logic [W-1:0]   din;
    logic           ir_in, din_out, g_out, a_in, g_in, addsub;
    logic [N-1:0]   r_out, r_in;
    logic [8:0]     ir;
    logic [W-1:0]   bus;
    logic           g_carry, g_zero, bus_conflict;
    logic [N*W-1:0] regs_flat;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    int checks = 0;
    int errors = 0;

    proc_datapath #(
        .WIDTH    (W),
        .NUM_REGS (N)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .din          (din),
        .ir_in        (ir_in),
        .din_out      (din_out),
        .g_out        (g_out),
        .r_out        (r_out),
        .r_in         (r_in),
        .a_in         (a_in),
        .g_in         (g_in),
        .addsub       (addsub),
        .ir           (ir),
        .bus          (bus),
        .g_carry      (g_carry),
        .g_zero       (g_zero),
        .bus_conflict (bus_conflict),
        .regs_flat    (regs_flat)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] observe(input int kind);
        if (kind < int'(N)) return 32'(regs_flat[kind*W +: W]);
        case (kind)
            K_BUS:      return 32'(bus);
            K_CARRY:    return 32'(g_carry);
            K_ZERO:     return 32'(g_zero);
            K_CONFLICT: return 32'(bus_conflict);
            K_IR:       return 32'(ir);
            default:    return 32'hDEAD_DEAD;
        endcase
    endfunction

    task automatic expect_v(input string tag, input int kind, input logic [31:0] v);
        sb.push_back('{tag: tag, kind: kind, exp: v});
    endtask

    task automatic check_all();
        sb_entry_t e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.kind);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic settle_check();
        #1;
        check_all();
    endtask

    task automatic clk_check();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic idle();
        din     = '0;
        ir_in   = 1'b0;
        din_out = 1'b0;
        g_out   = 1'b0;
        r_out   = '0;
        r_in    = '0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        addsub  = 1'b0;
    endtask

    // Drives G onto the bus to observe it, together with the flags.
    task automatic check_g(input string tag, input logic [W-1:0] g, input logic c,
                           input logic z);
        @(negedge clock);
        idle();
        g_out = 1'b1;
        expect_v({tag, "_g"}, K_BUS, 32'(g));
        expect_v({tag, "_carry"}, K_CARRY, 32'(c));
        expect_v({tag, "_zero"}, K_ZERO, 32'(z));
        settle_check();
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        #12;
        expect_v("rst_r0", 0, 32'h0);
        expect_v("rst_r7", 7, 32'h0);
        expect_v("rst_ir", K_IR, 32'h0);
        expect_v("rst_carry", K_CARRY, 32'h0);
        expect_v("rst_zero", K_ZERO, 32'h1);
        expect_v("rst_bus", K_BUS, 32'h0);
        expect_v("rst_conflict", K_CONFLICT, 32'h0);
        settle_check();
        @(negedge clock);
        resetn = 1'b1;

        // Load R7 so the asynchronous clear has something to clear
        @(negedge clock);
        idle();
        din = 16'hBEEF; din_out = 1'b1; r_in = 8'h80;
        expect_v("pre_r7", 7, 32'hBEEF);
        clk_check();

        // Reset mid-cycle with a load pending
        @(negedge clock);
        idle();
        din = 16'h1234; din_out = 1'b1; r_in = 8'h01;
        resetn = 1'b0;
        expect_v("async_clr_r7", 7, 32'h0);
        settle_check();
        expect_v("rst_load_r0", 0, 32'h0);
        expect_v("rst_load_zero", K_ZERO, 32'h1);
        clk_check();
        resetn = 1'b1;
        expect_v("post_rst_r0", 0, 32'h1234);
        clk_check();

        // mvi / mv
        @(negedge clock);
        idle();
        din = 16'h00FF; din_out = 1'b1; r_in = 8'h02;
        expect_v("mvi_r1", 1, 32'h00FF);
        clk_check();
        @(negedge clock);
        idle();
        r_out = 8'h02; r_in = 8'h80;
        expect_v("mv_bus", K_BUS, 32'h00FF);
        expect_v("mv_conflict", K_CONFLICT, 32'h0);
        settle_check();
        expect_v("mv_r7", 7, 32'h00FF);
        expect_v("mv_r1", 1, 32'h00FF);
        clk_check();

        // Self-reload plus fan-out: R1 stays, R0 picks up R1
        @(negedge clock);
        idle();
        r_out = 8'h02; r_in = 8'h03;
        expect_v("self_r1", 1, 32'h00FF);
        expect_v("fan_r0", 0, 32'h00FF);
        clk_check();

        // Add wrap: A = FFFF, R2 = 0001
        @(negedge clock);
        idle();
        din = 16'hFFFF; din_out = 1'b1; a_in = 1'b1;
        clk_check();
        @(negedge clock);
        idle();
        din = 16'h0001; din_out = 1'b1; r_in = 8'h04;
        expect_v("ld_r2", 2, 32'h0001);
        clk_check();
        @(negedge clock);
        idle();
        r_out = 8'h04; g_in = 1'b1; addsub = 1'b0;
        clk_check();
        check_g("add_wrap", 16'h0000, 1'b1, 1'b1);

        // Sub borrow: 3 - 5
        @(negedge clock);
        idle();
        din = 16'h0003; din_out = 1'b1; a_in = 1'b1;
        clk_check();
        @(negedge clock);
        idle();
        din = 16'h0005; din_out = 1'b1; g_in = 1'b1; addsub = 1'b1;
        clk_check();
        check_g("sub_borrow", 16'hFFFE, 1'b1, 1'b0);

        // Sub equal: 3 - 3 gives zero and no borrow
        @(negedge clock);
        idle();
        din = 16'h0003; din_out = 1'b1; g_in = 1'b1; addsub = 1'b1;
        clk_check();
        check_g("sub_equal", 16'h0000, 1'b0, 1'b1);

        // Conflicts resolve by priority
        @(negedge clock);
        idle();
        din = 16'h5555; din_out = 1'b1; r_in = 8'h08;
        clk_check();
        @(negedge clock);
        idle();
        din = 16'hAAAA; din_out = 1'b1; r_out = 8'h08;
        expect_v("cf_din_bus", K_BUS, 32'hAAAA);
        expect_v("cf_din_flag", K_CONFLICT, 32'h1);
        settle_check();
        @(negedge clock);
        idle();
        r_out = 8'h09;
        expect_v("cf_r0_bus", K_BUS, 32'h00FF);
        expect_v("cf_r0_flag", K_CONFLICT, 32'h1);
        settle_check();
        @(negedge clock);
        idle();
        g_out = 1'b1; r_out = 8'h08;
        expect_v("cf_g_bus", K_BUS, 32'h0000);
        expect_v("cf_g_flag", K_CONFLICT, 32'h1);
        expect_v("cf_r3_kept", 3, 32'h5555);
        settle_check();

        // a_in and g_in together: G uses old A
        @(negedge clock);
        idle();
        din = 16'h0010; din_out = 1'b1; a_in = 1'b1;
        clk_check();
        @(negedge clock);
        idle();
        din = 16'h0001; din_out = 1'b1; a_in = 1'b1; g_in = 1'b1;
        clk_check();
        check_g("agin", 16'h0011, 1'b0, 1'b0);
        // Empty bus exposes A through the adder
        @(negedge clock);
        idle();
        g_in = 1'b1;
        clk_check();
        check_g("new_a", 16'h0001, 1'b0, 1'b0);
        // g_out and g_in together: G <= A + old G
        @(negedge clock);
        idle();
        g_out = 1'b1; g_in = 1'b1;
        clk_check();
        check_g("ggin", 16'h0002, 1'b0, 1'b0);

        // IR loads from din even while another driver owns the bus
        @(negedge clock);
        idle();
        din = 16'h0177; ir_in = 1'b1; r_out = 8'h08;
        expect_v("ir_load", K_IR, 32'h177);
        clk_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
